// File: rtl/teclado_pkg.sv
// Shared definitions for the PS/2 keyboard path: scan codes, key indices,
// decoder state type and frame length.
package teclado_pkg;

  // PS/2 frame: start, 8 data bits, odd parity, stop.
  localparam int unsigned FRAME_LEN = 11;

  // Prefix codes.
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Normal (set 2) direction codes.
  localparam logic [7:0] SC_ARRIBA = 8'h1D;
  localparam logic [7:0] SC_ABAJO  = 8'h1B;
  localparam logic [7:0] SC_IZQ    = 8'h1C;
  localparam logic [7:0] SC_DER    = 8'h23;

  // Extended (E0-prefixed) direction codes: the arrow keys.
  localparam logic [7:0] SC_EXT_ARRIBA = 8'h75;
  localparam logic [7:0] SC_EXT_ABAJO  = 8'h72;
  localparam logic [7:0] SC_EXT_IZQ    = 8'h6B;
  localparam logic [7:0] SC_EXT_DER    = 8'h74;

  // Bit positions of the held key levels.
  localparam int unsigned KEY_ARRIBA = 0;
  localparam int unsigned KEY_ABAJO  = 1;
  localparam int unsigned KEY_IZQ    = 2;
  localparam int unsigned KEY_DER    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } dec_state_e;

  // One-hot key mask for a scan code; zero if the code is not a direction key.
  function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
    logic [3:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_EXT_ARRIBA: m[KEY_ARRIBA] = 1'b1;
        SC_EXT_ABAJO:  m[KEY_ABAJO]  = 1'b1;
        SC_EXT_IZQ:    m[KEY_IZQ]    = 1'b1;
        SC_EXT_DER:    m[KEY_DER]    = 1'b1;
        default:       m = '0;
      endcase
    end else begin
      case (code)
        SC_ARRIBA: m[KEY_ARRIBA] = 1'b1;
        SC_ABAJO:  m[KEY_ABAJO]  = 1'b1;
        SC_IZQ:    m[KEY_IZQ]    = 1'b1;
        SC_DER:    m[KEY_DER]    = 1'b1;
        default:   m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/teclado_ctrl_frame_rx.sv
// PS/2 frame receiver: synchronisers, falling-edge detect, shift register,
// bit counter, inactivity watchdog and frame checks.
// Optional: TECLADO_PARITY_CHECK_EN enables the odd-parity check on bit 9.
module ps2_frame_rx
  import teclado_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned    WdW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdLast  = WdW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     BitLast = 4'(FRAME_LEN - 1);

  logic clk_s1_q, clk_s2_q, clk_hist_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-2:0] shift_q, shift_d;
  logic [WdW-1:0]       wd_q, wd_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [FRAME_LEN-1:0] frame;
  logic                 frame_ok;

  // Synchronisers reset to 1 so an idle bus never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_hist_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_hist_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall = clk_hist_q & ~clk_s2_q;

  // Frame as it looks once the bit being sampled now is shifted in (LSB first).
  assign frame = {dat_s2_q, shift_q};

  // Start must be 0, stop must be 1; parity only when the check is built in.
  always_comb begin
    frame_ok = (frame[0] == 1'b0) && (frame[FRAME_LEN-1] == 1'b1);
`ifdef TECLADO_PARITY_CHECK_EN
    frame_ok = frame_ok && (^frame[9:1]);
`endif
  end

  // Receiver next state: shifting, frame completion and watchdog expiry.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wd_d      = wd_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      // A fall always beats a coincident timeout.
      shift_d = frame[FRAME_LEN-1:1];
      wd_d    = '0;
      if (bit_cnt_q == BitLast) begin
        bit_cnt_d = '0;
        if (frame_ok) begin
          byte_d  = frame[8:1];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (wd_q == WdLast) begin
        bit_cnt_d = '0;
        wd_d      = '0;
        err_d     = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Receiver state and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wd_q      <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wd_q      <= wd_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/teclado_ctrl.sv
// PS/2 keyboard sequencing controller: receives frames and decodes
// make/break/extended sequences into four held direction levels.
// Optional: TECLADO_PARITY_CHECK_EN (handled in the frame receiver).
module teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ClockT,
  input  logic       DataT,
  output logic [7:0] ScanCode,
  output logic       ScanValid,
  output logic       FrameErr,
  output logic       mArriba,
  output logic       mAbajo,
  output logic       mIzq,
  output logic       mDer
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  dec_state_e state_q, state_d;
  logic [3:0] keys_q, keys_d;

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk     (Clock),
    .rst     (Reset),
    .ps2_clk (ClockT),
    .ps2_dat (DataT),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  // Decoder state and key level registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  // Decoder next state; any frame error drops a pending prefix.
  always_comb begin
    state_d = state_q;
    if (rx_err) begin
      state_d = StIdle;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_byte == SC_BREAK) begin
            state_d = StBrk;
          end else if (rx_byte == SC_EXT) begin
            state_d = StExt;
          end
        end
        StBrk:    state_d = StIdle;
        StExt:    state_d = (rx_byte == SC_BREAK) ? StExtBrk : StIdle;
        StExtBrk: state_d = StIdle;
      endcase
    end
  end

  // Key updates: make sets, break clears; levels survive frame errors.
  always_comb begin
    keys_d = keys_q;
    if (rx_valid) begin
      unique case (state_q)
        StIdle:   keys_d = keys_q | key_mask(rx_byte, 1'b0);
        StBrk:    keys_d = keys_q & ~key_mask(rx_byte, 1'b0);
        StExt:    keys_d = keys_q | key_mask(rx_byte, 1'b1);
        StExtBrk: keys_d = keys_q & ~key_mask(rx_byte, 1'b1);
      endcase
    end
  end

  assign ScanCode  = rx_byte;
  assign ScanValid = rx_valid;
  assign FrameErr  = rx_err;
  assign mArriba   = keys_q[KEY_ARRIBA];
  assign mAbajo    = keys_q[KEY_ABAJO];
  assign mIzq      = keys_q[KEY_IZQ];
  assign mDer      = keys_q[KEY_DER];

endmodule

// File: tb/tb_teclado_ctrl.sv
// Self-checking bench for teclado_ctrl: directed scenarios followed by random
// frames, checked against a prefix-queue model of the key protocol.
module tb_teclado_ctrl;

  localparam int HALF = 20;   // PS/2 half-period in system cycles (scaled down)
  localparam int TO   = 200;  // watchdog length used for this bench

`ifdef TECLADO_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ClockT;
  logic       DataT;
  logic [7:0] ScanCode;
  logic       ScanValid;
  logic       FrameErr;
  logic       mArriba, mAbajo, mIzq, mDer;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: held keys (bit0 up, 1 down, 2 left, 3 right),
  // last good byte, and prefix bytes awaiting a final code.
  logic [3:0] m_keys;
  logic [7:0] m_code;
  logic [7:0] pend[$];
  logic [7:0] norm_codes[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  logic [7:0] ext_codes[4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] pool[10]      = '{8'hF0, 8'hE0, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                                8'h75, 8'h72, 8'h6B, 8'h74};

  wire [3:0] dut_keys = {mDer, mIzq, mAbajo, mArriba};

  teclado_ctrl #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ClockT   (ClockT),
    .DataT    (DataT),
    .ScanCode (ScanCode),
    .ScanValid(ScanValid),
    .FrameErr (FrameErr),
    .mArriba  (mArriba),
    .mAbajo   (mAbajo),
    .mIzq     (mIzq),
    .mDer     (mDer)
  );

  always #5 Clock = ~Clock;

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Prefixes accumulate (at most one E0 first, at most one F0); any other byte
  // completes the sequence and is looked up in the table chosen by the prefixes.
  task automatic model_byte(input logic [7:0] b);
    bit seen_brk;
    bit seen_ext;
    seen_brk = 1'b0;
    seen_ext = 1'b0;
    foreach (pend[i]) begin
      if (pend[i] == 8'hF0) seen_brk = 1'b1;
      if (pend[i] == 8'hE0) seen_ext = 1'b1;
    end
    if (b == 8'hF0 && !seen_brk) begin
      pend.push_back(b);
    end else if (b == 8'hE0 && pend.size() == 0) begin
      pend.push_back(b);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (b == (seen_ext ? ext_codes[k] : norm_codes[k])) m_keys[k] = !seen_brk;
      end
      pend.delete();
    end
  endtask

  task automatic model_reset();
    m_keys = '0;
    m_code = '0;
    pend.delete();
  endtask

  task automatic ps2_bit(input logic b);
    DataT = b;
    repeat (HALF) @(negedge Clock);
    ClockT = 1'b0;
    repeat (HALF) @(negedge Clock);
    ClockT = 1'b1;
  endtask

  // Called just after the raw fall of the stop bit. Checks strobe latency,
  // strobe type, ScanCode, and that keys change exactly one cycle later.
  task automatic await_strobe(input bit good, input logic [7:0] b);
    int         t;
    logic [3:0] keys_before;
    logic [7:0] code_before;
    t           = 0;
    keys_before = m_keys;
    code_before = m_code;
    while (!(ScanValid || FrameErr) && t < 8) begin
      @(negedge Clock);
      t++;
    end
    chk("strobe_seen", 32'(t < 8), 32'd1);
    if (t < 8) begin
      chk("strobe_latency", 32'(t >= 3 && t <= 4), 32'd1);
      chk("scan_valid", 32'(ScanValid), 32'(good));
      chk("frame_err", 32'(FrameErr), 32'(!good));
      chk("scan_code", 32'(ScanCode), 32'(good ? b : code_before));
      chk("keys_n1", 32'(dut_keys), 32'(keys_before));
      if (good) begin
        m_code = b;
        model_byte(b);
      end else begin
        pend.delete();
      end
      @(negedge Clock);
      chk("strobe_width", 32'({ScanValid, FrameErr}), 32'd0);
      chk("keys_n2", 32'(dut_keys), 32'(m_keys));
    end
  endtask

  // kind: 0 good, 1 bad stop, 2 bad parity, 3 bad start.
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    bit          good;
    f[0]    = (kind == 3);
    f[8:1]  = b;
    f[9]    = ~(^b) ^ (kind == 2);
    f[10]   = (kind != 1);
    good    = (f[0] == 1'b0) && (f[10] == 1'b1) && (!PAR_EN || (^f[9:1]));
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    DataT = f[10];
    repeat (HALF) @(negedge Clock);
    ClockT = 1'b0;
    await_strobe(good, b);
    repeat (HALF) @(negedge Clock);
    ClockT = 1'b1;
    DataT  = 1'b1;
    repeat (HALF) @(negedge Clock);
  endtask

  initial begin
    int errs;
    int vals;
    int first_err;
    logic [7:0] b;
    int kind;

    ClockT = 1'b1;
    DataT  = 1'b1;
    Reset  = 1'b1;
    model_reset();
    repeat (3) @(negedge Clock);
    chk("rst_scan_code", 32'(ScanCode), 32'h00);
    chk("rst_strobes", 32'({ScanValid, FrameErr}), 32'd0);
    chk("rst_keys", 32'(dut_keys), 32'd0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    // Make and break of up.
    send_frame(8'h1D, 0);
    chk("up_made", 32'(mArriba), 32'd1);
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    chk("up_broken", 32'(mArriba), 32'd0);

    // Extended left make/break; others untouched.
    send_frame(8'hE0, 0);
    send_frame(8'h6B, 0);
    chk("ext_left_made", 32'(dut_keys), 32'b0100);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h6B, 0);
    chk("ext_left_broken", 32'(dut_keys), 32'b0000);

    // Two keys held together, one released.
    send_frame(8'h1C, 0);
    send_frame(8'h23, 0);
    chk("two_held", 32'(dut_keys), 32'b1100);
    send_frame(8'h1C, 0);  // typematic repeat
    chk("repeat_nochange", 32'(dut_keys), 32'b1100);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    chk("one_released", 32'(dut_keys), 32'b1000);

    // Bad frames.
    send_frame(8'h55, 1);
    send_frame(8'h1B, 2);
    chk("parity_case_down", 32'(mAbajo), 32'(!PAR_EN));
    if (!PAR_EN) begin
      send_frame(8'hF0, 0);
      send_frame(8'h1B, 0);
    end

    // Partial frame abandoned by the watchdog.
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    errs      = 0;
    vals      = 0;
    first_err = -1;
    for (int t = 1; t <= TO + 60; t++) begin
      @(negedge Clock);
      if (FrameErr) begin
        errs++;
        if (first_err < 0) first_err = t;
      end
      if (ScanValid) vals++;
    end
    pend.delete();
    chk("timeout_err_count", 32'(errs), 32'd1);
    chk("timeout_valid_count", 32'(vals), 32'd0);
    chk("timeout_position", 32'(first_err >= TO - HALF - 10 && first_err <= TO - HALF + 10),
        32'd1);
    chk("timeout_keys", 32'(dut_keys), 32'(m_keys));
    send_frame(8'h1B, 0);
    chk("down_after_timeout", 32'(mAbajo), 32'd1);

    // Reset during bit 6 of a frame while right is held.
    chk("right_held_pre_reset", 32'(mDer), 32'd1);
    for (int i = 0; i < 6; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    DataT = 1'b1;
    repeat (HALF / 2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    chk("midrst_keys", 32'(dut_keys), 32'd0);
    chk("midrst_code", 32'(ScanCode), 32'h00);
    chk("midrst_strobes", 32'({ScanValid, FrameErr}), 32'd0);
    repeat (2 * HALF) @(negedge Clock);
    send_frame(8'h1D, 0);
    chk("post_reset_decode", 32'(dut_keys), 32'b0001);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 7) b = pool[$urandom_range(0, 9)];
      else b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       kind = 1;
        1:       kind = 2;
        2:       kind = 3;
        default: kind = 0;
      endcase
      send_frame(b, kind);
    end
    chk("final_keys", 32'(dut_keys), 32'(m_keys));
    chk("final_code", 32'(ScanCode), 32'(m_code));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
